// File: rtl/dmi_responder.sv
// dmi_responder
//   DM-side endpoint of the DTM<->DM debug-module-interface link.
//   Requests arrive from the JTAG DTM as a 4-phase full handshake in a
//   foreign clock domain. The request and acknowledge levels are
//   resynchronized here. Each request issues at most one register access on
//   a valid/ready port. The result goes back to the DTM over a second 4-phase
//   handshake in DMI response format {addr, data, status}.
//
// Ports
//   clk, rst                   DM clock, asynchronous active-high reset
//   dtm_req_valid_i            request level from the DTM (asynchronous)
//   dtm_req_data_i             {addr, wdata, op}, stable while valid is high
//   dm_ack_o                   request acknowledge to the DTM
//   dm_resp_o, dm_resp_data_o  response level and {addr, rdata, status}
//   dtm_ack_i                  DTM acknowledge of the response (asynchronous)
//   dm_req_*_o, dm_req_ready_i register access request port
//   dm_rsp_*_i                 register access completion (valid is a pulse)
//   busy_o                     high whenever the FSM is not idle
module dmi_responder #(
  parameter int DMI_ADDR_BITS = 6,
  parameter int DMI_DATA_BITS = 32,
  parameter int DMI_OP_BITS   = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int DM_TIMEOUT    = 255,
  parameter int REQ_BITS      = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS,
  parameter int RESP_BITS     = REQ_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dtm_req_valid_i,
  input  logic [REQ_BITS-1:0]      dtm_req_data_i,
  output logic                     dm_ack_o,
  output logic                     dm_resp_o,
  output logic [RESP_BITS-1:0]     dm_resp_data_o,
  input  logic                     dtm_ack_i,
  output logic                     dm_req_valid_o,
  input  logic                     dm_req_ready_i,
  output logic                     dm_req_we_o,
  output logic [DMI_ADDR_BITS-1:0] dm_req_addr_o,
  output logic [DMI_DATA_BITS-1:0] dm_req_wdata_o,
  input  logic                     dm_rsp_valid_i,
  input  logic [DMI_DATA_BITS-1:0] dm_rsp_rdata_i,
  input  logic                     dm_rsp_err_i,
  output logic                     busy_o
);

  localparam logic [DMI_OP_BITS-1:0] OP_NOP      = '0;
  localparam logic [DMI_OP_BITS-1:0] OP_READ     = DMI_OP_BITS'(1);
  localparam logic [DMI_OP_BITS-1:0] OP_WRITE    = DMI_OP_BITS'(2);
  localparam logic [DMI_OP_BITS-1:0] STATUS_OK   = '0;
  localparam logic [DMI_OP_BITS-1:0] STATUS_FAIL = DMI_OP_BITS'(2);

  // Counter only has to reach DM_TIMEOUT-1.
  localparam int TW = (DM_TIMEOUT > 1) ? $clog2(DM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((DM_TIMEOUT > 0) ? DM_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ_REL, S_ACCESS, S_WAIT, S_RESP, S_RESP_REL
  } state_t;

  state_t                   state_q;
  logic [SYNC_STAGES-1:0]   req_sync_q;
  logic [SYNC_STAGES-1:0]   ack_sync_q;
  logic [DMI_ADDR_BITS-1:0] addr_q;
  logic [DMI_DATA_BITS-1:0] wdata_q;
  logic [DMI_OP_BITS-1:0]   op_q;
  logic [TW-1:0]            cnt_q;
  logic                     dm_ack_q;
  logic                     dm_resp_q;
  logic [RESP_BITS-1:0]     dm_resp_data_q;
  logic                     dm_req_valid_q;
  logic                     dm_req_we_q;
  logic [DMI_ADDR_BITS-1:0] dm_req_addr_q;
  logic [DMI_DATA_BITS-1:0] dm_req_wdata_q;

  logic                     req_s;
  logic                     ack_s;
  logic                     timed_out;
  logic [DMI_DATA_BITS-1:0] rsp_rdata_sel;
  logic [DMI_OP_BITS-1:0]   rsp_status_sel;

  assign req_s = req_sync_q[SYNC_STAGES-1];
  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  // Timeout fires on the DM_TIMEOUT-th edge after entering ACCESS.
  assign timed_out = (DM_TIMEOUT != 0) && (cnt_q == TO_LAST);

  // Writes return zero data even though the register file drives rdata.
  assign rsp_rdata_sel  = (op_q == OP_READ) ? dm_rsp_rdata_i : '0;
  assign rsp_status_sel = dm_rsp_err_i ? STATUS_FAIL : STATUS_OK;

  // Plain flop chains on the two asynchronous handshake levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_sync_q <= '0;
      ack_sync_q <= '0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], dtm_req_valid_i};
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], dtm_ack_i};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      op_q           <= '0;
      cnt_q          <= '0;
      dm_ack_q       <= 1'b0;
      dm_resp_q      <= 1'b0;
      dm_resp_data_q <= '0;
      dm_req_valid_q <= 1'b0;
      dm_req_we_q    <= 1'b0;
      dm_req_addr_q  <= '0;
      dm_req_wdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_s) begin
            addr_q   <= dtm_req_data_i[REQ_BITS-1 -: DMI_ADDR_BITS];
            wdata_q  <= dtm_req_data_i[DMI_OP_BITS +: DMI_DATA_BITS];
            op_q     <= dtm_req_data_i[DMI_OP_BITS-1:0];
            dm_ack_q <= 1'b1;
            state_q  <= S_REQ_REL;
          end
        end
        S_REQ_REL: begin
          if (!req_s) begin
            dm_ack_q <= 1'b0;
            if (op_q == OP_READ || op_q == OP_WRITE) begin
              dm_req_valid_q <= 1'b1;
              dm_req_we_q    <= (op_q == OP_WRITE);
              dm_req_addr_q  <= addr_q;
              dm_req_wdata_q <= wdata_q;
              cnt_q          <= '0;
              state_q        <= S_ACCESS;
            end else begin
              // No register access: NOP succeeds, reserved op fails.
              dm_resp_data_q <= {addr_q, {DMI_DATA_BITS{1'b0}},
                                 (op_q == OP_NOP) ? STATUS_OK : STATUS_FAIL};
              dm_resp_q      <= 1'b1;
              state_q        <= S_RESP;
            end
          end
        end
        S_ACCESS: begin
          cnt_q <= cnt_q + 1'b1;
          if (dm_req_ready_i && dm_rsp_valid_i) begin
            // Combinational register file: completion arrives with ready.
            dm_req_valid_q <= 1'b0;
            dm_resp_data_q <= {addr_q, rsp_rdata_sel, rsp_status_sel};
            dm_resp_q      <= 1'b1;
            state_q        <= S_RESP;
          end else if (timed_out) begin
            dm_req_valid_q <= 1'b0;
            dm_resp_data_q <= {addr_q, {DMI_DATA_BITS{1'b0}}, STATUS_FAIL};
            dm_resp_q      <= 1'b1;
            state_q        <= S_RESP;
          end else if (dm_req_ready_i) begin
            dm_req_valid_q <= 1'b0;
            state_q        <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (dm_rsp_valid_i) begin
            dm_resp_data_q <= {addr_q, rsp_rdata_sel, rsp_status_sel};
            dm_resp_q      <= 1'b1;
            state_q        <= S_RESP;
          end else if (timed_out) begin
            dm_resp_data_q <= {addr_q, {DMI_DATA_BITS{1'b0}}, STATUS_FAIL};
            dm_resp_q      <= 1'b1;
            state_q        <= S_RESP;
          end
        end
        S_RESP: begin
          if (ack_s) begin
            dm_resp_q <= 1'b0;
            state_q   <= S_RESP_REL;
          end
        end
        S_RESP_REL: begin
          if (!ack_s) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dm_ack_o       = dm_ack_q;
  assign dm_resp_o      = dm_resp_q;
  assign dm_resp_data_o = dm_resp_data_q;
  assign dm_req_valid_o = dm_req_valid_q;
  assign dm_req_we_o    = dm_req_we_q;
  assign dm_req_addr_o  = dm_req_addr_q;
  assign dm_req_wdata_o = dm_req_wdata_q;
  assign busy_o         = (state_q != S_IDLE);

endmodule
